// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and capture blocks.
//   DUTY_W          - duty command / measurement width
//   CW_DEFAULT      - default width of the period and high-time counters
//   TIMEOUT_DEFAULT - default clocks without a rising edge before "stuck"
//   cap_state_t     - capture FSM states
package pwm_pkg;

    localparam int unsigned DUTY_W          = 8;
    localparam int unsigned CW_DEFAULT      = 20;
    localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

    // ST_ACQ  : waiting for the first rising edge; partial period is discarded
    // ST_RUN  : every rising edge closes a full period measurement
    // ST_STUCK: no rising edge for TIMEOUT clocks; duty forced to 0 or 255
    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_RUN   = 2'd1,
        ST_STUCK = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_frac_div.sv
// pwm_frac_div: serial restoring divider producing q = min(255, floor(H*256/P)).
//   clk, rst - clock, synchronous active-low reset
//   start    - load H/P and begin a divide (ignored while busy)
//   abort    - cancel any divide in progress (wins over start)
//   H, P     - high time and period in clocks
//   busy     - divide in progress
//   q        - quotient, valid in the cycle where done is high
//   done     - high in the cycle of the final iteration (combinational)
module pwm_frac_div
    import pwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CW-1:0]     H,
    input  logic [CW-1:0]     P,
    input  logic              abort,
    output logic              busy,
    output logic [DUTY_W-1:0] q,
    output logic              done
);

    localparam int unsigned IW = $clog2(DUTY_W);

    logic [CW:0]       rem;
    logic [CW-1:0]     div;
    logic [DUTY_W-1:0] quo;
    logic [IW-1:0]     iter;
    logic              ovf;

    logic [CW:0]       rem_sh;
    logic [CW:0]       rem_nx;
    logic              ge;
    logic [DUTY_W-1:0] quo_nx;

    // One restoring step; the last step's quotient is presented directly on q
    // so the top level can register it on the same edge the divide finishes.
    always_comb begin
        rem_sh = rem << 1;
        ge     = (rem_sh >= {1'b0, div});
        rem_nx = ge ? (rem_sh - {1'b0, div}) : rem_sh;
        quo_nx = {quo[DUTY_W-2:0], ge};
        done   = busy && (iter == IW'(DUTY_W - 1));
        q      = ovf ? '1 : quo_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem  <= '0;
            div  <= '0;
            quo  <= '0;
            iter <= '0;
            ovf  <= 1'b0;
            busy <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            rem  <= {1'b0, H};
            div  <= P;
            quo  <= '0;
            iter <= '0;
            // H >= P would overflow 8 quotient bits; clamp to full scale
            ovf  <= (H >= P);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            iter <= iter + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the 8-bit duty of an incoming PWM waveform.
//   CW, TIMEOUT - counter width, clocks without rising edge before "stuck"
//   clk         - system clock
//   rst         - synchronous active-low reset
//   pwm_in      - asynchronous PWM input
//   duty        - latest measured duty (0 = always low, 255 = always high)
//   duty_valid  - one-cycle pulse when duty updates
//   stuck       - high from timeout until the next divider result
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CW      = CW_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              stuck
);

    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_PRE = CW'(TIMEOUT - 1);

    logic s1, s2, s3;
    logic rise, fall;

    logic [CW-1:0] pcnt;
    logic [CW-1:0] hcnt;

    cap_state_t state;

    logic              timeout_hit;
    logic              enter_stuck;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_q;

    // STUCK is entered on the edge where pcnt reaches TIMEOUT, so the test
    // looks one count ahead. A rising edge always takes precedence.
    always_comb begin
        rise        = s2 & ~s3;
        fall        = ~s2 & s3;
        timeout_hit = !rise && (pcnt >= TO_PRE);
        enter_stuck = (state != ST_STUCK) && timeout_hit;
        // Snapshots arriving while the divider is busy are dropped.
        div_start   = (state == ST_RUN) && rise && !div_busy;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            pcnt       <= '0;
            hcnt       <= '0;
            state      <= ST_ACQ;
            duty       <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;

            if (rise) begin
                pcnt <= CW'(1);
                hcnt <= CW'(1);
            end else if ((state == ST_STUCK) && fall) begin
                pcnt <= CW'(1);
                hcnt <= '0;
            end else begin
                if (pcnt != TO_MAX) begin
                    pcnt <= pcnt + 1'b1;
                end
                if (s2 && (hcnt != TO_MAX)) begin
                    hcnt <= hcnt + 1'b1;
                end
            end

            duty_valid <= 1'b0;

            // Timeout entry overrides a divider result finishing on the same
            // edge; the divider is aborted through enter_stuck.
            if (enter_stuck) begin
                state      <= ST_STUCK;
                duty       <= s2 ? '1 : '0;
                duty_valid <= 1'b1;
                stuck      <= 1'b1;
            end else begin
                if (div_done) begin
                    duty       <= div_q;
                    duty_valid <= 1'b1;
                    stuck      <= 1'b0;
                end
                case (state)
                    ST_ACQ: begin
                        if (rise) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        state <= ST_RUN;
                    end
                    ST_STUCK: begin
                        if (rise) begin
                            state <= ST_RUN;
                        end else if (fall) begin
                            state <= ST_ACQ;
                        end
                    end
                    default: begin
                        state <= ST_ACQ;
                    end
                endcase
            end
        end
    end

    pwm_frac_div #(
        .CW (CW)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .H     (hcnt),
        .P     (pcnt),
        .abort (enter_stuck),
        .busy  (div_busy),
        .q     (div_q),
        .done  (div_done)
    );

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
module tb_pwm_capture;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [7:0] duty;
    logic       duty_valid;
    logic       stuck;

    int total = 0;
    int bad   = 0;

    // Waveform source: either the generator or a manual level
    logic gen_level;
    logic man_level = 1'b0;
    bit   gen_on = 1'b0;
    int   gen_period = 1000;
    int   gen_high = 250;
    int   wave_epoch = 0;

    assign pwm_in = gen_on ? gen_level : man_level;

    // Observed duty_valid events
    logic [7:0] vq_duty[$];
    logic       vq_stuck[$];
    int         dbl = 0;
    logic       prev_v = 1'b0;

    pwm_capture #(
        .CW      (20),
        .TIMEOUT (5000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // PWM generator; a new epoch restarts the phase with a rising edge
    initial begin
        int ph;
        int seen;
        ph = 0;
        seen = 0;
        gen_level = 1'b0;
        forever begin
            @(negedge clk);
            if (seen != wave_epoch) begin
                seen = wave_epoch;
                ph = 0;
            end
            gen_level = (ph < gen_high);
            ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (duty_valid) begin
            vq_duty.push_back(duty);
            vq_stuck.push_back(stuck);
            if (prev_v) dbl++;
        end
        prev_v = duty_valid;
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: ideal duty from the waveform's high time and period
    function automatic int exp_duty(input int hi, input int per);
        int q;
        q = (hi * 256) / per;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic flush();
        vq_duty.delete();
        vq_stuck.delete();
    endtask

    task automatic wait_valid(input int budget, output bit got,
                              output logic [7:0] d, output logic s);
        got = 1'b0;
        d = '0;
        s = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vq_duty.size() > 0) begin
                d = vq_duty.pop_front();
                s = vq_stuck.pop_front();
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_wave(input int p, input int h);
        @(posedge clk);
        #2;
        gen_period = p;
        gen_high = h;
        wave_epoch++;
        gen_on = 1'b1;
    endtask

    task automatic go_manual(input logic v);
        @(posedge clk);
        #2;
        man_level = v;
        gen_on = 1'b0;
    endtask

    // Measures one waveform and compares against the reference within tol
    task automatic measure(input string name, input int p, input int h, input int tol);
        bit got;
        logic [7:0] d;
        logic s;
        int e;
        set_wave(p, h);
        repeat (p + 20) @(negedge clk);
        flush();
        wait_valid(2 * p + 100, got, d, s);
        e = exp_duty(h, p);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_valid: got no duty_valid, required one within %0d cycles", name, 2 * p + 100);
        end
        total++;
        if (absdiff(int'(d), e) > tol) begin
            bad++;
            $display("FAIL %s_duty: p=%0d h=%0d got %0d required %0d +/-%0d", name, p, h, d, e, tol);
        end
        total++;
        if (s !== 1'b0) begin
            bad++;
            $display("FAIL %s_stuck: got %b required 0", name, s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (duty !== 8'd0) begin bad++; $display("FAIL reset_duty: got %0d required 0", duty); end
        total++;
        if (duty_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", duty_valid); end
        total++;
        if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck: got %b required 0", stuck); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        int k;
        bit got;
        go_manual(1'b0);
        repeat (10) @(negedge clk);
        flush();
        man_level = 1'b1;
        repeat (5) @(negedge clk);
        man_level = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (vq_duty.size() != 0) begin
            bad++;
            $display("FAIL first_period_discarded: got %0d duty_valid pulses required 0", vq_duty.size());
        end
        man_level = 1'b1;
        k = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (duty_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got || k != 11) begin
            bad++;
            $display("FAIL latency: got valid=%b after %0d edges required valid after edge 10 (count 11)", got, k);
        end
        total++;
        if (duty !== 8'd64) begin bad++; $display("FAIL latency_duty: got %0d required 64", duty); end
        total++;
        if (stuck !== 1'b0) begin bad++; $display("FAIL latency_stuck: got %b required 0", stuck); end
    endtask

    task automatic test_reset_mid_divide();
        bit got;
        logic [7:0] d;
        logic s;
        @(negedge clk);
        man_level = 1'b0;
        repeat (20) @(negedge clk);
        flush();
        total++;
        if (duty !== 8'd64) begin bad++; $display("FAIL pre_reset_duty: got %0d required 64", duty); end
        man_level = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (duty !== 8'd0) begin bad++; $display("FAIL mid_reset_duty: got %0d required 0", duty); end
        total++;
        if (duty_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b required 0", duty_valid); end
        total++;
        if (stuck !== 1'b0) begin bad++; $display("FAIL mid_reset_stuck: got %b required 0", stuck); end
        @(negedge clk);
        man_level = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        flush();
        wait_valid(40, got, d, s);
        total++;
        if (got) begin bad++; $display("FAIL aborted_divide: got duty_valid duty=%0d required none", d); end
        set_wave(100, 30);
        wait_valid(400, got, d, s);
        total++;
        if (!got || d !== 8'(exp_duty(30, 100))) begin
            bad++;
            $display("FAIL post_reset_duty: got valid=%b duty=%0d required %0d", got, d, exp_duty(30, 100));
        end
    endtask

    task automatic test_fixed();
        measure("p1000_h250", 1000, 250, 0);
        measure("p1000_h500", 1000, 500, 0);
        measure("p256_h100", 256, 100, 0);
        measure("p256_h255", 256, 255, 1);
        measure("loop_cmd100", 256, 100, 1);
        measure("loop_cmd50", 256, 50, 1);
        measure("loop_cmd200", 256, 200, 1);
    endtask

    task automatic test_random();
        int p;
        int h;
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(600, 16));
            h = int'($urandom_range(p - 1, 1));
            measure("random", p, h, 1);
        end
    endtask

    task automatic test_stuck();
        bit got;
        logic [7:0] d;
        logic s;
        int k;
        measure("pre_stuck", 1000, 250, 0);
        go_manual(1'b1);
        repeat (30) @(negedge clk);
        flush();
        wait_valid(6000, got, d, s);
        total++;
        if (!got || d !== 8'd255) begin
            bad++;
            $display("FAIL stuck_high_duty: got valid=%b duty=%0d required 255", got, d);
        end
        total++;
        if (s !== 1'b1) begin bad++; $display("FAIL stuck_high_flag: got %b required 1", s); end
        wait_valid(200, got, d, s);
        total++;
        if (got) begin bad++; $display("FAIL stuck_single_pulse: got extra duty_valid duty=%0d required none", d); end
        total++;
        if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_hold: got %b required 1", stuck); end
        @(negedge clk);
        man_level = 1'b0;
        k = 0;
        got = 1'b0;
        for (int i = 0; i < 5100; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (duty_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got || k != 5002) begin
            bad++;
            $display("FAIL stuck_low_timing: got valid=%b after %0d edges required count 5002", got, k);
        end
        total++;
        if (duty !== 8'd0) begin bad++; $display("FAIL stuck_low_duty: got %0d required 0", duty); end
        total++;
        if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_low_flag: got %b required 1", stuck); end
        @(negedge clk);
        flush();
        set_wave(1000, 250);
        repeat (500) @(negedge clk);
        total++;
        if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_until_result: got %b required 1", stuck); end
        wait_valid(2100, got, d, s);
        total++;
        if (!got || d !== 8'd64) begin
            bad++;
            $display("FAIL resume_duty: got valid=%b duty=%0d required 64", got, d);
        end
        total++;
        if (s !== 1'b0) begin bad++; $display("FAIL resume_stuck: got %b required 0", s); end
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        set_wave(8, 4);
        repeat (40) @(negedge clk);
        flush();
        base = dbl;
        repeat (400) @(negedge clk);
        n = vq_duty.size();
        total++;
        if (n < 10 || n > 45) begin
            bad++;
            $display("FAIL b2b_count: got %0d reports required 10..45", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (vq_duty[i] !== 8'd128) begin
                bad++;
                $display("FAIL b2b_duty[%0d]: got %0d required 128", i, vq_duty[i]);
            end
        end
        total++;
        if (dbl != base) begin
            bad++;
            $display("FAIL b2b_consecutive: got %0d consecutive-cycle pulses required 0", dbl - base);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_latency();
        test_reset_mid_divide();
        test_fixed();
        test_random();
        test_stuck();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
